csr_timer: RTL and testbench
============================

# csr_timer

Machine-timer peripheral on the core's CSR side-port. It holds a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, both accessible through the `csr_*` handshake of `Pipeline`. It drives `irq_timer` into the core, so it sits directly upstream of the pipeline's timer-interrupt input and CSR read-data path.

## Interface
- `DIVIDER`, default 1: clock cycles per `mtime` increment. Legal values are ≥1; 1 means increment every cycle.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `csr_read`  in  1: core reads the CSR at `csr_addr` this cycle.
- `csr_write`  in  1: core writes `csr_wdata` to `csr_addr` this cycle.
- `csr_addr`  in  12: CSR number.
- `csr_wdata`  in  32: final write value. The core has already resolved set/clear semantics.
- `csr_rdata`  out  32: read data. Registered.
- `csr_valid`  out  1: block claims the access. Registered, single-cycle pulse.
- `irq_timer`  out  1: timer interrupt request. Registered, level.

## Operation
- Address map (all others are ignored):
  - 0xC01 `time`: read-only, returns `mtime[31:0]` and latches `mtime[63:32]` into `shadow_hi`.
  - 0xC81 `timeh`: read-only, returns `shadow_hi`.
  - 0x7C0 `mtime`: RW low word. Reads return live `mtime[31:0]` and do not latch.
  - 0x7C1 `mtimeh`: RW high word, live.
  - 0x7C2 `mtimecmp`: RW low word.
  - 0x7C3 `mtimecmph`: RW high word.
- Access claiming:
  - An access is `csr_read | csr_write` with a mapped address.
  - Unmapped addresses leave `csr_valid` = 0 and `csr_rdata` = 0, so the core traps or another decoder answers.
  - Writes to 0xC01/0xC81 are claimed (`csr_valid` = 1) but have no effect.
- Read-modify-write: with `csr_read` and `csr_write` both high, the read returns the pre-write value and the write applies at the same edge.
- Prescaler: a counter `pre` counts 0..DIVIDER-1. On `pre == DIVIDER-1`, `pre` ← 0 and `mtime` increments. For DIVIDER=1 the prescaler is constant and `mtime` increments every cycle.
- Arithmetic:
  - `mtime` is a 64-bit unsigned increment with carry from bit 31 into bit 32.
  - 0xFFFFFFFF_FFFFFFFF wraps to 0.
- Write priority:
  - A write to 0x7C0 or 0x7C1 overrides the increment for that half in that cycle.
  - The other half still receives carry only if the increment happened and the carry came from the unwritten low half. Writing the low word suppresses the carry into the high word.
  - Writes do not reset `pre`.
- Interrupt:
  - `irq_timer` ← (`mtime_next` >= `mtimecmp_next`), unsigned 64-bit compare, evaluated on post-update values.
  - Writing a larger `mtimecmp` therefore clears the IRQ on the following edge.
- No other state and no FSM beyond the prescaler.

## Timing
- Reset values:
  - `mtime` = 0, `mtimecmp` = 0xFFFFFFFF_FFFFFFFF, `shadow_hi` = 0, `pre` = 0.
  - `csr_rdata` = 0, `csr_valid` = 0, `irq_timer` = 0.
- Read latency:
  - Request in cycle N gives `csr_valid`/`csr_rdata` in cycle N+1.
  - Data reflects the register value at the end of cycle N, before the edge.
  - Outputs return to 0 in N+2 unless a new request arrives.
- Back-to-back requests are accepted every cycle. There is no busy state and no backpressure.
- Write latency: the value is visible to a read issued in cycle N+1, and to `irq_timer` in cycle N+1.
- `irq_timer` latency: asserted in the cycle after `mtime` reaches `mtimecmp`.
- `shadow_hi` updates at the edge ending the `time` read cycle. A `timeh` read in the next cycle returns that snapshot even if `mtime` carried in between.
- Reset asserted mid-access:
  - All outputs drop to reset values immediately (asynchronous).
  - A pending response is lost. The core must not rely on it.

## Test plan
- Reset, DIVIDER=1, no access for 10 cycles → read 0x7C0 in cycle 10 → `csr_valid` = 1, `csr_rdata` = 10 (±1 per the documented edge), `irq_timer` = 0.
- DIVIDER=4, run 40 cycles → `mtime` = 10. Then write 0x7C0 = 0x1234 → next read returns 0x1234 plus elapsed increments, and `pre` phase is unchanged.
- Write 0x7C0 = 0xFFFFFFFE and 0x7C1 = 0, DIVIDER=1 → after 2 increments 0x7C1 reads 1 and 0x7C0 reads 0. From all-ones, it wraps to `mtime` = 0.
- Set `mtime` = 0xFFFFFFFF, read 0xC01 → returns 0xFFFFFFFF and latches hi = 0. Next-cycle read of 0xC81 returns 0, while 0x7C1 live reads 1.
- Write `mtimecmp` = 20 (hi 0) with `mtime` = 0 → `irq_timer` rises the cycle after `mtime` = 20. Writing 0x7C2 = 0xFFFF clears it the next cycle. A simultaneous read+write to 0x7C2 returns the old value 20.
- Access 0x300 → `csr_valid` = 0, `csr_rdata` = 0. Assert `reset` mid-read → `csr_valid` drops immediately and `mtimecmp` returns to all-ones.

Source files
------------

// File: rtl/csr_timer_if.sv
// CSR side-port bundle between the core and the machine-timer peripheral.
// The core drives requests; the peripheral returns registered read data and claim.
interface csr_timer_if;
  logic        csr_read;
  logic        csr_write;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_valid;

  modport master (
    output csr_read, csr_write, csr_addr, csr_wdata,
    input  csr_rdata, csr_valid
  );

  modport slave (
    input  csr_read, csr_write, csr_addr, csr_wdata,
    output csr_rdata, csr_valid
  );
endinterface

// File: rtl/csr_timer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, and a level
// timer interrupt, all reached through the core's CSR side-port.
module csr_timer #(
  parameter int unsigned DIVIDER = 1
) (
  input  logic        clock,
  input  logic        reset,
  csr_timer_if.slave  bus,
  output logic        irq_timer
);

  localparam int unsigned PRE_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIVIDER - 1);

  localparam logic [11:0] ADDR_TIME      = 12'hC01;
  localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
  localparam logic [11:0] ADDR_MTIME     = 12'h7C0;
  localparam logic [11:0] ADDR_MTIMEH    = 12'h7C1;
  localparam logic [11:0] ADDR_MTIMECMP  = 12'h7C2;
  localparam logic [11:0] ADDR_MTIMECMPH = 12'h7C3;

  logic [PRE_W-1:0] pre;
  logic [31:0]      mtime_lo;
  logic [31:0]      mtime_hi;
  logic [31:0]      cmp_lo;
  logic [31:0]      cmp_hi;
  logic [31:0]      shadow_hi;

  logic             tick_c;
  logic [PRE_W-1:0] pre_next_c;
  logic [32:0]      lo_sum_c;
  logic             wr_lo_c;
  logic             wr_hi_c;
  logic             wr_cmp_lo_c;
  logic             wr_cmp_hi_c;
  logic [31:0]      mtime_lo_next_c;
  logic [31:0]      mtime_hi_next_c;
  logic [31:0]      cmp_lo_next_c;
  logic [31:0]      cmp_hi_next_c;
  logic             irq_next_c;
  logic             mapped_c;
  logic             claim_c;
  logic             latch_shadow_c;
  logic [31:0]      rdata_c;

  // Prescaler, counter increment with low-to-high carry, and write overrides.
  always_comb begin
    tick_c          = 1'b0;
    pre_next_c      = pre;
    lo_sum_c        = '0;
    wr_lo_c         = 1'b0;
    wr_hi_c         = 1'b0;
    wr_cmp_lo_c     = 1'b0;
    wr_cmp_hi_c     = 1'b0;
    mtime_lo_next_c = mtime_lo;
    mtime_hi_next_c = mtime_hi;
    cmp_lo_next_c   = cmp_lo;
    cmp_hi_next_c   = cmp_hi;
    irq_next_c      = 1'b0;

    tick_c     = (pre == PRE_MAX);
    pre_next_c = tick_c ? '0 : pre + PRE_W'(1);
    lo_sum_c   = {1'b0, mtime_lo} + {32'd0, tick_c};

    wr_lo_c     = bus.csr_write && (bus.csr_addr == ADDR_MTIME);
    wr_hi_c     = bus.csr_write && (bus.csr_addr == ADDR_MTIMEH);
    wr_cmp_lo_c = bus.csr_write && (bus.csr_addr == ADDR_MTIMECMP);
    wr_cmp_hi_c = bus.csr_write && (bus.csr_addr == ADDR_MTIMECMPH);

    // A written low word discards its own carry so the high word stays put.
    mtime_lo_next_c = wr_lo_c ? bus.csr_wdata : lo_sum_c[31:0];
    mtime_hi_next_c = wr_hi_c ? bus.csr_wdata
                              : mtime_hi + {31'd0, lo_sum_c[32] & ~wr_lo_c};
    cmp_lo_next_c   = wr_cmp_lo_c ? bus.csr_wdata : cmp_lo;
    cmp_hi_next_c   = wr_cmp_hi_c ? bus.csr_wdata : cmp_hi;

    irq_next_c = ({mtime_hi_next_c, mtime_lo_next_c} >= {cmp_hi_next_c, cmp_lo_next_c});
  end

  // Address decode and pre-write read mux.
  always_comb begin
    mapped_c       = 1'b0;
    claim_c        = 1'b0;
    latch_shadow_c = 1'b0;
    rdata_c        = '0;

    case (bus.csr_addr)
      ADDR_TIME:      begin mapped_c = 1'b1; rdata_c = mtime_lo;  end
      ADDR_TIMEH:     begin mapped_c = 1'b1; rdata_c = shadow_hi; end
      ADDR_MTIME:     begin mapped_c = 1'b1; rdata_c = mtime_lo;  end
      ADDR_MTIMEH:    begin mapped_c = 1'b1; rdata_c = mtime_hi;  end
      ADDR_MTIMECMP:  begin mapped_c = 1'b1; rdata_c = cmp_lo;    end
      ADDR_MTIMECMPH: begin mapped_c = 1'b1; rdata_c = cmp_hi;    end
      default:        begin mapped_c = 1'b0; rdata_c = '0;        end
    endcase

    claim_c        = (bus.csr_read || bus.csr_write) && mapped_c;
    latch_shadow_c = bus.csr_read && (bus.csr_addr == ADDR_TIME);
    if (!bus.csr_read) begin
      rdata_c = '0;
    end
  end

  // Timer state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      mtime_lo  <= '0;
      mtime_hi  <= '0;
      cmp_lo    <= '1;
      cmp_hi    <= '1;
      shadow_hi <= '0;
    end else begin
      pre      <= pre_next_c;
      mtime_lo <= mtime_lo_next_c;
      mtime_hi <= mtime_hi_next_c;
      cmp_lo   <= cmp_lo_next_c;
      cmp_hi   <= cmp_hi_next_c;
      if (latch_shadow_c) begin
        shadow_hi <= mtime_hi;
      end
    end
  end

  // Registered response and interrupt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.csr_valid <= 1'b0;
      bus.csr_rdata <= '0;
      irq_timer     <= 1'b0;
    end else begin
      bus.csr_valid <= claim_c;
      bus.csr_rdata <= claim_c ? rdata_c : 32'd0;
      irq_timer     <= irq_next_c;
    end
  end

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: one instance with DIVIDER=1, one with DIVIDER=4,
// driven through their CSR interfaces with hand-computed expectations.
module tb_csr_timer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic irq1;
  logic irq4;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic        v_s;
  logic [31:0] d_s;
  logic        irq_s;

  csr_timer_if bus1 ();
  csr_timer_if bus4 ();

  csr_timer #(.DIVIDER(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1), .irq_timer(irq1));
  csr_timer #(.DIVIDER(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4), .irq_timer(irq4));

  always #5 clock = ~clock;

  task automatic clear_bus();
    bus1.csr_read = 1'b0; bus1.csr_write = 1'b0; bus1.csr_addr = '0; bus1.csr_wdata = '0;
    bus4.csr_read = 1'b0; bus4.csr_write = 1'b0; bus4.csr_addr = '0; bus4.csr_wdata = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one request for one cycle, capture the response just after the edge.
  task automatic access(input bit d4, input bit rd, input bit wr,
                        input logic [11:0] a, input logic [31:0] wd);
    if (d4) begin
      bus4.csr_read = rd; bus4.csr_write = wr; bus4.csr_addr = a; bus4.csr_wdata = wd;
    end else begin
      bus1.csr_read = rd; bus1.csr_write = wr; bus1.csr_addr = a; bus1.csr_wdata = wd;
    end
    @(posedge clock);
    #1;
    if (d4) begin
      v_s = bus4.csr_valid; d_s = bus4.csr_rdata; irq_s = irq4;
    end else begin
      v_s = bus1.csr_valid; d_s = bus1.csr_rdata; irq_s = irq1;
    end
    clear_bus();
  endtask

  task automatic do_reset();
    clear_bus();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_bus();
    reset = 1'b1;
    tick(2);
    checks++; if (bus1.csr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus1.csr_valid); end
    checks++; if (bus1.csr_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus1.csr_rdata); end
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq1); end
    reset = 1'b0;
    tick(10);
    access(1'b0, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (v_s !== 1'b1) begin errors++; $display("FAIL run10_valid got %b want 1", v_s); end
    checks++; if (d_s !== 32'd10) begin errors++; $display("FAIL run10_rdata got %h want 0000000a", d_s); end
    checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL run10_irq got %b want 0", irq_s); end
    tick(1);
    checks++; if (bus1.csr_valid !== 1'b0 || bus1.csr_rdata !== 32'd0) begin
      errors++; $display("FAIL idle_return got %b/%h want 0/0", bus1.csr_valid, bus1.csr_rdata);
    end
  endtask

  task automatic test_prescaler();
    do_reset();
    tick(40);
    access(1'b1, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'd10) begin errors++; $display("FAIL div4_40 got %h want 0000000a", d_s); end
    access(1'b1, 1'b0, 1'b1, 12'h7C0, 32'h1234);
    checks++; if (v_s !== 1'b1 || d_s !== 32'd0) begin errors++; $display("FAIL div4_wr got %b/%h want 1/0", v_s, d_s); end
    access(1'b1, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'h1234) begin errors++; $display("FAIL div4_rd1 got %h want 00001234", d_s); end
    access(1'b1, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'h1234) begin errors++; $display("FAIL div4_rd2 got %h want 00001234", d_s); end
    access(1'b1, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'h1235) begin errors++; $display("FAIL div4_phase got %h want 00001235", d_s); end
  endtask

  task automatic test_carry();
    do_reset();
    access(1'b0, 1'b0, 1'b1, 12'h7C1, 32'd0);
    access(1'b0, 1'b0, 1'b1, 12'h7C0, 32'hFFFF_FFFE);
    access(1'b0, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'hFFFF_FFFE) begin errors++; $display("FAIL carry_lo0 got %h want fffffffe", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C1, 32'd0);
    checks++; if (d_s !== 32'd0) begin errors++; $display("FAIL carry_hi0 got %h want 0", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C1, 32'd0);
    checks++; if (d_s !== 32'd1) begin errors++; $display("FAIL carry_hi1 got %h want 1", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'd1) begin errors++; $display("FAIL carry_lo1 got %h want 1", d_s); end
    // Writing the low word while it is all-ones must not carry.
    access(1'b0, 1'b0, 1'b1, 12'h7C1, 32'd0);
    access(1'b0, 1'b0, 1'b1, 12'h7C0, 32'hFFFF_FFFE);
    tick(1);
    access(1'b0, 1'b0, 1'b1, 12'h7C0, 32'd5);
    access(1'b0, 1'b1, 1'b0, 12'h7C1, 32'd0);
    checks++; if (d_s !== 32'd0) begin errors++; $display("FAIL carry_suppress got %h want 0", d_s); end
    // Full 64-bit wrap from all-ones.
    access(1'b0, 1'b0, 1'b1, 12'h7C1, 32'hFFFF_FFFF);
    access(1'b0, 1'b0, 1'b1, 12'h7C0, 32'hFFFF_FFFF);
    checks++; if (irq_s !== 1'b1) begin errors++; $display("FAIL allones_irq got %b want 1", irq_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C1, 32'd0);
    checks++; if (d_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hi_pre got %h want ffffffff", d_s); end
    checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL wrap_irq got %b want 0", irq_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'd0) begin errors++; $display("FAIL wrap_lo got %h want 0", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C1, 32'd0);
    checks++; if (d_s !== 32'd0) begin errors++; $display("FAIL wrap_hi got %h want 0", d_s); end
  endtask

  task automatic test_shadow();
    do_reset();
    access(1'b0, 1'b0, 1'b1, 12'h7C1, 32'd0);
    access(1'b0, 1'b0, 1'b1, 12'h7C0, 32'hFFFF_FFFF);
    access(1'b0, 1'b1, 1'b0, 12'hC01, 32'd0);
    checks++; if (v_s !== 1'b1 || d_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL time_rd got %b/%h want 1/ffffffff", v_s, d_s); end
    access(1'b0, 1'b1, 1'b0, 12'hC81, 32'd0);
    checks++; if (d_s !== 32'd0) begin errors++; $display("FAIL timeh_snap got %h want 0", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C1, 32'd0);
    checks++; if (d_s !== 32'd1) begin errors++; $display("FAIL mtimeh_live got %h want 1", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'hC01, 32'd0);
    checks++; if (d_s !== 32'd2) begin errors++; $display("FAIL time_rd2 got %h want 2", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'hC81, 32'd0);
    checks++; if (d_s !== 32'd1) begin errors++; $display("FAIL timeh_snap2 got %h want 1", d_s); end
    access(1'b0, 1'b0, 1'b1, 12'hC01, 32'h55);
    checks++; if (v_s !== 1'b1) begin errors++; $display("FAIL time_wr_claim got %b want 1", v_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C0, 32'd0);
    checks++; if (d_s !== 32'd5) begin errors++; $display("FAIL time_wr_noeffect got %h want 5", d_s); end
  endtask

  task automatic test_irq();
    do_reset();
    access(1'b0, 1'b0, 1'b1, 12'h7C3, 32'd0);
    access(1'b0, 1'b0, 1'b1, 12'h7C2, 32'd20);
    checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq_s); end
    tick(17);
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_at19 got %b want 0", irq1); end
    tick(1);
    checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL irq_at20 got %b want 1", irq1); end
    access(1'b0, 1'b1, 1'b1, 12'h7C2, 32'h0000_FFFF);
    checks++; if (d_s !== 32'd20) begin errors++; $display("FAIL rmw_old got %h want 00000014", d_s); end
    checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C2, 32'd0);
    checks++; if (d_s !== 32'h0000_FFFF) begin errors++; $display("FAIL cmp_new got %h want 0000ffff", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C3, 32'd0);
    checks++; if (d_s !== 32'd0) begin errors++; $display("FAIL cmph got %h want 0", d_s); end
  endtask

  task automatic test_unmapped();
    do_reset();
    access(1'b0, 1'b1, 1'b0, 12'h300, 32'd0);
    checks++; if (v_s !== 1'b0 || d_s !== 32'd0) begin errors++; $display("FAIL unmapped_rd got %b/%h want 0/0", v_s, d_s); end
    access(1'b0, 1'b1, 1'b1, 12'h7C4, 32'd9);
    checks++; if (v_s !== 1'b0 || d_s !== 32'd0) begin errors++; $display("FAIL unmapped_7c4 got %b/%h want 0/0", v_s, d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C2, 32'd0);
    checks++; if (d_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped_noeffect got %h want ffffffff", d_s); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, 1'b0, 12'h7C0, 32'd0);
      checks++; if (v_s !== 1'b1 || d_s !== 32'(i)) begin
        errors++; $display("FAIL b2b_%0d got %b/%h want 1/%h", i, v_s, d_s, 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    access(1'b0, 1'b0, 1'b1, 12'h7C2, 32'd5);
    bus1.csr_read = 1'b1; bus1.csr_addr = 12'h7C2;
    @(posedge clock);
    #1;
    checks++; if (bus1.csr_valid !== 1'b1 || bus1.csr_rdata !== 32'd5) begin
      errors++; $display("FAIL pre_mid got %b/%h want 1/5", bus1.csr_valid, bus1.csr_rdata);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus1.csr_valid !== 1'b0 || bus1.csr_rdata !== 32'd0) begin
      errors++; $display("FAIL mid_reset got %b/%h want 0/0", bus1.csr_valid, bus1.csr_rdata);
    end
    clear_bus();
    @(posedge clock);
    #1;
    reset = 1'b0;
    access(1'b0, 1'b1, 1'b0, 12'h7C2, 32'd0);
    checks++; if (d_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_rst_lo got %h want ffffffff", d_s); end
    access(1'b0, 1'b1, 1'b0, 12'h7C3, 32'd0);
    checks++; if (d_s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_rst_hi got %h want ffffffff", d_s); end
  endtask

  initial begin
    clear_bus();
    test_reset();
    test_prescaler();
    test_carry();
    test_shadow();
    test_irq();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
